// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART byte transmitter.
// Idle timeout force-releases a requester that stalls mid-message.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_timeout
);

  localparam int PW   = $clog2(N_REQ);
  localparam int CW   = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLIM = (TIMEOUT_CYCLES > 0) ?
                        TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] C_EXP = CW'(TLIM);
  localparam logic [CW-1:0] C_SAT = '1;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [PW-1:0]    r_own;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_timeout;

  logic             w_found;
  logic [PW-1:0]    w_pick;
  logic [N_REQ-1:0] w_pick_oh;
  logic [7:0]       w_sel_data;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_locked;
  logic             w_xfer;
  logic [N_REQ-1:0] w_rdy;
  int               w_j;

  // Scan starts one past the last released owner, wrapping around.
  always_comb begin
    w_found   = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    w_j       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_j = (int'(r_ptr) + i) % N_REQ;
      if (!w_found && i_req_valid[w_j]) begin
        w_found = 1'b1;
        w_pick  = PW'(w_j);
      end
    end
    w_pick_oh[w_pick] = 1'b1;
  end

  always_comb begin
    w_sel_data  = 8'h00;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_own == PW'(k)) begin
        w_sel_data  = i_req_data[8*k +: 8];
        w_sel_valid = i_req_valid[k];
        w_sel_last  = i_req_last[k];
      end
    end
  end

  assign w_locked = (r_state == S_LOCKED);
  assign w_xfer   = w_locked & w_sel_valid & i_tx_ready;

  always_comb begin
    w_rdy = '0;
    if (w_locked) w_rdy[r_own] = i_tx_ready;
  end

  assign o_req_ready = w_rdy;
  assign o_grant     = r_grant;
  assign o_tx_valid  = w_locked & w_sel_valid;
  assign o_tx_data   = w_locked ? w_sel_data : 8'h00;
  assign o_timeout   = r_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_own     <= '0;
      r_ptr     <= PW'(N_REQ - 1);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_state <= S_LOCKED;
            r_own   <= w_pick;
            r_grant <= w_pick_oh;
          end
        end
        S_LOCKED: begin
          if (w_xfer && w_sel_last) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= r_own;
            r_cnt   <= '0;
          end else if (w_sel_valid) begin
            r_cnt <= '0;
          end else if (TIMEOUT_CYCLES > 0 && r_cnt == C_EXP) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= r_own;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
          end else if (TIMEOUT_CYCLES > 0 && r_cnt != C_SAT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random message backlogs against
// a round-robin message model, plus directed timeout/busy/reset cases.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           tmo;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_data (req_data),
    .i_req_valid(req_valid),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_grant    (grant),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_timeout  (tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         req;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] q_d[N][$];
  logic       q_l[N][$];
  int         bi[N];
  int         gap[N];
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         sb_on  = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every emitter transfer must match the head of the queue.
  always @(negedge clk) begin
    if (sb_on && rst_n && tx_valid && tx_ready) begin
      logic [N-1:0] oh;
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", 32'(tx_data), 32'hffff_ffff);
      end else begin
        e  = exp_q.pop_front();
        oh = '0;
        oh[e.req] = 1'b1;
        chk("sb_byte", {16'h0, tx_data, 4'h0, req_ready},
            {16'h0, e.data, 4'h0, oh});
        chk("sb_grant", 32'(grant), 32'(oh));
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_msgs();
    for (int k = 0; k < N; k++) begin
      q_d[k].delete();
      q_l[k].delete();
    end
  endtask

  task automatic load_random(input logic [N-1:0] mask, input int maxlen);
    int nm, len;
    clear_msgs();
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        nm = $urandom_range(1, 3);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, maxlen);
          for (int b = 0; b < len; b++) begin
            q_d[k].push_back(8'($urandom));
            q_l[k].push_back(b == len - 1);
          end
        end
      end
    end
  endtask

  // Whole messages go out in round-robin order among backlogged requesters.
  task automatic build_expect();
    int   rem[N];
    int   pos[N];
    int   ptr, pick, left;
    exp_t e;
    left = 0;
    for (int k = 0; k < N; k++) begin
      pos[k] = 0;
      rem[k] = 0;
      foreach (q_l[k][b]) if (q_l[k][b]) rem[k]++;
      left += rem[k];
    end
    ptr = N - 1;
    while (left > 0) begin
      pick = -1;
      for (int i = 1; i <= N; i++) begin
        if (pick < 0 && rem[(ptr + i) % N] > 0) pick = (ptr + i) % N;
      end
      do begin
        e.req  = pick;
        e.data = q_d[pick][pos[pick]];
        exp_q.push_back(e);
        pos[pick]++;
      end while (!q_l[pick][pos[pick]-1]);
      rem[pick]--;
      left--;
      ptr = pick;
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      req_last[k] = 1'b0;
      if (gap[k] > 0) begin
        req_valid[k] = 1'b0;
        req_data[8*k +: 8] = 8'($urandom);
        gap[k]--;
      end else if (bi[k] < q_d[k].size()) begin
        req_valid[k] = 1'b1;
        req_data[8*k +: 8] = q_d[k][bi[k]];
        req_last[k] = q_l[k][bi[k]];
      end else begin
        req_valid[k] = 1'b0;
        req_data[8*k +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic run_sched(string tag);
    logic [N-1:0] acc;
    int cyc, to_cnt;
    bit done;
    exp_q.delete();
    build_expect();
    do_reset();
    for (int k = 0; k < N; k++) begin
      bi[k]  = 0;
      gap[k] = 0;
    end
    tx_ready = 1'b1;
    sb_on    = 1'b1;
    drive_inputs();
    cyc    = 0;
    to_cnt = 0;
    done   = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      if (tmo) to_cnt++;
      tick();
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          bi[k]++;
          if (!q_l[k][bi[k]-1]) gap[k] = $urandom_range(0, 3);
        end
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      drive_inputs();
      cyc++;
      done = 1'b1;
      for (int k = 0; k < N; k++)
        if (bi[k] < q_d[k].size()) done = 1'b0;
    end
    @(negedge clk);
    sb_on = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_drained"}, exp_q.size(), 32'd0);
    chk({tag, "_no_timeout"}, to_cnt, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    int  viol;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_timeout", 32'(tmo), 32'd0);
    rst_n = 1'b1;

    clear_msgs();
    q_d[1].push_back(8'h41); q_l[1].push_back(1'b0);
    q_d[1].push_back(8'h42); q_l[1].push_back(1'b1);
    run_sched("req1_two_bytes");
    load_random(4'b0101, 1);
    run_sched("pair_0_2");
    load_random(4'b1111, 4);
    run_sched("all_four");
    load_random(4'b1010, 3);
    run_sched("pair_1_3");
    for (int r = 0; r < 3; r++) begin
      load_random(4'($urandom_range(1, 15)), 4);
      run_sched("rand_mask");
    end

    // Timeout: valid returning on the expiry cycle, then a real stall.
    do_reset();
    tx_ready = 1'b1;
    req_valid = 4'b1100;
    req_data  = {8'h33, 8'h77, 8'h00, 8'h00};
    req_last  = '0;
    tick();
    @(negedge clk);
    chk("to_lock_grant", 32'(grant), 32'h4);
    chk("to_lock_data", 32'(tx_data), 32'h77);
    chk("to_lock_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      tick();
      @(negedge clk);
      seen |= tmo;
    end
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'h78;
    #1;
    chk("to_rise_data", 32'(tx_data), 32'h78);
    tick();
    @(negedge clk);
    chk("to_rise_no_pulse", 32'(seen | tmo), 32'd0);
    chk("to_rise_grant", 32'(grant), 32'h4);
    req_valid[2] = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      @(negedge clk);
      seen = tmo;
    end
    chk("to_latency", n, 32'd16);
    chk("to_grant_cleared", 32'(grant), 32'd0);
    tick();
    @(negedge clk);
    chk("to_next_grant", 32'(grant), 32'h8);
    chk("to_next_data", {tx_valid, tx_data}, {1'b1, 8'h33});
    chk("to_pulse_single", 32'(tmo), 32'd0);

    // Emitter busy with valid held: no handshake, no timeout.
    tx_ready = 1'b0;
    viol = 0;
    repeat (50) begin
      tick();
      @(negedge clk);
      if (tmo || !tx_valid || tx_data !== 8'h33 ||
          req_ready !== '0 || grant !== 4'h8) viol++;
    end
    chk("busy_violations", viol, 32'd0);
    req_last[3] = 1'b1;
    tx_ready    = 1'b1;
    tick();
    @(negedge clk);
    chk("busy_release", 32'(grant), 32'd0);
    req_valid = 4'b0010;
    req_last  = '0;
    req_data[15:8] = 8'h55;

    // Reset mid-message, then requester 0 wins.
    tick();
    @(negedge clk);
    chk("mid_lock_grant", 32'(grant), 32'h2);
    tick();
    req_data[15:8] = 8'h56;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    tick();
    @(negedge clk);
    chk("post_rst_priority", 32'(grant), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
